// File: rtl/hr_beat_scheduler.sv
// Heart-rate beat scheduler.
// Measures the R-R interval in ms ticks, rejects beats inside the refractory
// window, launches the external 60000/interval divider and publishes the
// instantaneous and 4-beat averaged heart rate. Flags asystole and divider
// timeouts.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_FIRST | idle; the next beat edge only starts an interval
// MEASURE    | counting ticks since the last accepted beat
// LAUNCH     | one-cycle divider start pulse
// WAIT_DIV   | waiting for div_done or the timeout; one beat may queue
module hr_beat_scheduler #(
  parameter int MIN_INTERVAL = 250,
  parameter int MAX_INTERVAL = 3000,
  parameter int DIV_TIMEOUT  = 1023
) (
  input  logic        qzt_clk,
  input  logic        rst_n,
  input  logic        tick_ms,
  input  logic        beat,
  output logic        div_start,
  output logic [15:0] div_divisor,
  input  logic        div_done,
  input  logic [15:0] div_quot,
  output logic [15:0] hr,
  output logic [15:0] hr_avg,
  output logic        hr_valid,
  output logic        beat_reject,
  output logic        asystole,
  output logic        err_div
);

  localparam int TW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [15:0] MIN_IVL = 16'(MIN_INTERVAL);
  localparam logic [15:0] MAX_IVL = 16'(MAX_INTERVAL);
  localparam logic [TW-1:0] TO_LAST = TW'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    LAUNCH     = 2'd2,
    WAIT_DIV   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [15:0]   ivl;
  logic [TW-1:0] tcnt;
  logic          beat_d;
  logic          pending;
  logic [15:0]   hist [4];
  logic          hist_empty;

  logic          beat_e;
  logic          evt;
  logic          first_beat;
  logic          accept;
  logic          reject_now;
  logic          set_pending;
  logic          clr_pending;
  logic          asys_now;
  logic          div_ok;
  logic          div_to;
  logic [15:0]   hist_nx [4];
  logic [17:0]   sum_nx;

  assign beat_e = beat & ~beat_d;
  // A beat queued during the division is evaluated as if it arrived now.
  assign evt    = beat_e | pending;

  // State register.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_FIRST;
    else        state <= state_nx;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nx    = state;
    first_beat  = 1'b0;
    accept      = 1'b0;
    reject_now  = 1'b0;
    set_pending = 1'b0;
    clr_pending = 1'b0;
    asys_now    = 1'b0;
    div_ok      = 1'b0;
    div_to      = 1'b0;
    div_start   = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (beat_e) begin
          first_beat = 1'b1;
          state_nx   = MEASURE;
        end
      end
      MEASURE: begin
        clr_pending = pending;
        if (evt && ivl >= MIN_IVL) begin
          accept   = 1'b1;
          state_nx = LAUNCH;
        end else begin
          reject_now = evt;
          if (ivl >= MAX_IVL) begin
            asys_now = 1'b1;
            state_nx = WAIT_FIRST;
          end
        end
      end
      LAUNCH: begin
        div_start = 1'b1;
        state_nx  = WAIT_DIV;
        if (beat_e) begin
          if (pending) reject_now  = 1'b1;
          else         set_pending = 1'b1;
        end
      end
      WAIT_DIV: begin
        if (beat_e) begin
          if (pending) reject_now  = 1'b1;
          else         set_pending = 1'b1;
        end
        if (div_done) begin
          div_ok   = 1'b1;
          state_nx = MEASURE;
        end else if (tcnt == TO_LAST) begin
          div_to   = 1'b1;
          state_nx = MEASURE;
        end
      end
      default: state_nx = WAIT_FIRST;
    endcase
  end

  // History after shifting in the new result; an empty history is preloaded.
  always_comb begin
    for (int i = 0; i < 4; i++) hist_nx[i] = div_quot;
    if (!hist_empty) begin
      hist_nx[1] = hist[0];
      hist_nx[2] = hist[1];
      hist_nx[3] = hist[2];
    end
    sum_nx = 18'(hist_nx[0]) + 18'(hist_nx[1]) + 18'(hist_nx[2]) + 18'(hist_nx[3]);
  end

  // Beat edge register, interval counter and divider timeout counter.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_d <= 1'b0;
      ivl    <= '0;
      tcnt   <= '0;
    end else begin
      beat_d <= beat;
      if (first_beat || accept)
        ivl <= '0;
      else if (state != WAIT_FIRST && tick_ms && ivl < MAX_IVL)
        ivl <= ivl + 16'd1;
      if (state == WAIT_DIV) tcnt <= tcnt + TW'(1);
      else                   tcnt <= '0;
    end
  end

  // Result history, published outputs and status flags.
  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      hist_empty  <= 1'b1;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      div_divisor <= '0;
      hr          <= '0;
      hr_avg      <= '0;
      hr_valid    <= 1'b0;
      beat_reject <= 1'b0;
      asystole    <= 1'b0;
      err_div     <= 1'b0;
    end else begin
      hr_valid    <= div_ok;
      beat_reject <= reject_now;
      if (set_pending)      pending <= 1'b1;
      else if (clr_pending) pending <= 1'b0;
      if (accept) div_divisor <= ivl;
      if (first_beat) asystole <= 1'b0;
      if (asys_now) begin
        asystole   <= 1'b1;
        hr         <= '0;
        hr_avg     <= '0;
        hist_empty <= 1'b1;
      end
      if (div_ok) begin
        for (int i = 0; i < 4; i++) hist[i] <= hist_nx[i];
        hist_empty <= 1'b0;
        hr         <= div_quot;
        hr_avg     <= sum_nx[17:2];
        err_div    <= 1'b0;
      end
      if (div_to) err_div <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hr_beat_scheduler.sv
// Directed bench for hr_beat_scheduler with a behavioural divider stub.
module tb_hr_beat_scheduler;

  logic        qzt_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_ms = 1'b0;
  logic        beat = 1'b0;
  logic        div_done = 1'b0;
  logic [15:0] div_quot = '0;
  logic        div_start;
  logic [15:0] div_divisor;
  logic [15:0] hr;
  logic [15:0] hr_avg;
  logic        hr_valid;
  logic        beat_reject;
  logic        asystole;
  logic        err_div;

  int vectors = 0;
  int miscompares = 0;
  int n_start = 0;
  int n_valid = 0;
  int n_reject = 0;
  bit div_en = 1'b1;
  int div_lat = 10;

  hr_beat_scheduler dut (
    .qzt_clk(qzt_clk), .rst_n(rst_n), .tick_ms(tick_ms), .beat(beat),
    .div_start(div_start), .div_divisor(div_divisor), .div_done(div_done),
    .div_quot(div_quot), .hr(hr), .hr_avg(hr_avg), .hr_valid(hr_valid),
    .beat_reject(beat_reject), .asystole(asystole), .err_div(err_div)
  );

  always #5 qzt_clk = ~qzt_clk;

  // Strobe counters, sampled away from the active edge.
  always @(negedge qzt_clk) begin
    if (div_start)   n_start++;
    if (hr_valid)    n_valid++;
    if (beat_reject) n_reject++;
  end

  // Divider stub: answers 60000/divisor after div_lat cycles when enabled.
  initial begin
    int q;
    forever begin
      @(negedge qzt_clk);
      if (div_start && div_en) begin
        q = 60000 / int'(div_divisor);
        repeat (div_lat) @(negedge qzt_clk);
        div_quot = 16'(q);
        div_done = 1'b1;
        @(negedge qzt_clk);
        div_done = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge qzt_clk);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick_ms = 1'b1;
      @(negedge qzt_clk);
      tick_ms = 1'b0;
      @(negedge qzt_clk);
    end
  endtask

  task automatic do_beat();
    beat = 1'b1;
    @(negedge qzt_clk);
    beat = 1'b0;
    @(negedge qzt_clk);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge qzt_clk);
      if (hr_valid) seen = 1'b1;
    end
    check(tag, int'(seen), 1);
    cyc(3);
  endtask

  initial begin
    int s0, v0, r0;
    cyc(3);
    check("rst_hr", int'(hr), 0);
    check("rst_hr_avg", int'(hr_avg), 0);
    check("rst_flags", int'({div_start, hr_valid, beat_reject, asystole, err_div}), 0);
    check("rst_divisor", int'(div_divisor), 0);
    rst_n = 1'b1;
    cyc(2);

    // First beat only starts the interval; second beat 1000 ticks later.
    do_beat();
    cyc(20);
    check("first_no_start", n_start, 0);
    tick_n(1000);
    do_beat();
    wait_valid("valid_1000");
    check("divisor_1000", int'(div_divisor), 1000);
    check("start_cnt_1", n_start, 1);
    check("hr_60", int'(hr), 60);
    check("avg_60", int'(hr_avg), 60);
    cyc(10);
    check("valid_cnt_1", n_valid, 1);

    // 500-tick intervals walk the average up toward 120.
    tick_n(500); do_beat(); wait_valid("valid_500a");
    check("hr_120", int'(hr), 120);
    check("avg_75", int'(hr_avg), 75);
    tick_n(500); do_beat(); wait_valid("valid_500b");
    check("avg_90", int'(hr_avg), 90);
    tick_n(500); do_beat(); wait_valid("valid_500c");
    check("avg_105", int'(hr_avg), 105);
    tick_n(500); do_beat(); wait_valid("valid_500d");
    check("avg_120", int'(hr_avg), 120);
    check("valid_cnt_5", n_valid, 5);

    // Refractory reject; interval keeps running to 800.
    s0 = n_start; r0 = n_reject;
    tick_n(100); do_beat(); cyc(5);
    check("reject_pulse", n_reject, r0 + 1);
    check("reject_no_start", n_start, s0);
    tick_n(700); do_beat(); wait_valid("valid_800");
    check("divisor_800", int'(div_divisor), 800);
    check("hr_75", int'(hr), 75);
    check("avg_108", int'(hr_avg), 108);

    // Asystole boundary at 3000 ticks.
    tick_n(2999);
    check("asys_not_yet", int'(asystole), 0);
    tick_n(1);
    check("asys_set", int'(asystole), 1);
    check("asys_hr", int'(hr), 0);
    check("asys_avg", int'(hr_avg), 0);
    s0 = n_start;
    do_beat(); cyc(20);
    check("asys_clear", int'(asystole), 0);
    check("asys_no_start", n_start, s0);
    tick_n(1000); do_beat(); wait_valid("valid_after_asys");
    check("hr_60_again", int'(hr), 60);
    check("avg_preload_60", int'(hr_avg), 60);

    // Divider never answers: timeout after 1023 cycles.
    div_en = 1'b0;
    v0 = n_valid;
    tick_n(500); do_beat();
    cyc(900);
    check("err_not_yet", int'(err_div), 0);
    cyc(200);
    check("err_set", int'(err_div), 1);
    check("err_hr_kept", int'(hr), 60);
    check("err_no_valid", n_valid, v0);
    div_en = 1'b1;
    tick_n(500); do_beat(); wait_valid("valid_after_err");
    check("err_cleared", int'(err_div), 0);
    check("hr_120_after_err", int'(hr), 120);
    check("avg_75_after_err", int'(hr_avg), 75);

    // Reset during WAIT_DIV; the divider answer lands after reset.
    div_lat = 30;
    v0 = n_valid;
    tick_n(500); do_beat();
    cyc(5);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(60);
    check("mid_rst_hr", int'(hr), 0);
    check("mid_rst_avg", int'(hr_avg), 0);
    check("mid_rst_flags", int'({hr_valid, beat_reject, asystole, err_div}), 0);
    check("mid_rst_divisor", int'(div_divisor), 0);
    check("mid_rst_no_valid", n_valid, v0);
    s0 = n_start;
    do_beat(); cyc(20);
    check("mid_rst_first_no_start", n_start, s0);
    tick_n(1000); do_beat(); wait_valid("valid_after_rst");
    check("hr_60_after_rst", int'(hr), 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
